// File: rtl/udp_stream_pkg.sv
// Shared types and constants for the UDP line-streaming transmit path.
// The UPL header plus one application header word precede every line payload.
package udp_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_FILL,
        ST_REQ,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int UPL_HDR_WORDS   = 3;
    localparam int APP_HDR_WORDS   = 1;
    localparam int HDR_WORDS       = UPL_HDR_WORDS + APP_HDR_WORDS;

    localparam int HDR_IDX_IP      = 0;
    localparam int HDR_IDX_PORTS   = 1;
    localparam int HDR_IDX_LEN     = 2;
    localparam int HDR_IDX_APP     = 3;

    localparam int PAYLOAD_BYTES_W = 16;

    // The UDP length counts the application header word along with the line payload.
    function automatic logic [PAYLOAD_BYTES_W-1:0] payload_bytes(input int line_words);
        return PAYLOAD_BYTES_W'((line_words + APP_HDR_WORDS) * 4);
    endfunction

endpackage

// File: rtl/udp_stream_sender_line_buf_fifo.sv
// Single-clock line buffer with show-ahead output: dout always presents the oldest word.
module line_buf_fifo #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           din,
    input  logic                  we,
    input  logic                  re,
    output logic [31:0]           dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_wr, do_rd;

    assign full  = (count_q == DEPTH[DEPTH_LOG2:0]);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    assign do_wr = we && !full;
    assign do_rd = re && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr && !do_rd) count_d = count_q + 1'b1;
        else if (!do_wr && do_rd) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/udp_stream_sender.sv
// Reads a frame from DRAM one line at a time and sends each line as one UDP packet
// through the UPL send port, prefixed by UDP and application header words.
module udp_stream_sender
    import udp_stream_pkg::*;
#(
    parameter int LINE_WORDS      = 256,
    parameter int FIFO_DEPTH_LOG2 = 10,
    parameter int GAP_CYCLES      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_lines,
    input  logic [31:0] base_addr,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    output logic        sending,
    output logic        done,
    output logic [15:0] frame_no,
    output logic        overflow,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] read_num,
    output logic [31:0] read_addr,
    input  logic [31:0] buf_dout,
    input  logic        buf_we,
    output logic        w_req,
    input  logic        w_ack,
    output logic        w_enable,
    output logic [31:0] w_data
);

    localparam logic [FIFO_DEPTH_LOG2:0] LINE_CNT = LINE_WORDS[FIFO_DEPTH_LOG2:0];
    localparam logic [15:0] LAST_WORD   = 16'(HDR_WORDS + LINE_WORDS - 1);
    localparam logic [31:0] LINE_BYTES  = 32'(LINE_WORDS * 4);
    localparam logic [31:0] GAP_LAST    = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [PAYLOAD_BYTES_W-1:0] PAYLOAD_BYTES = payload_bytes(LINE_WORDS);

    state_t      state_q, state_d;
    logic [15:0] line_q, line_d;
    logic [15:0] num_lines_q, num_lines_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [31:0] ports_q, ports_d;
    logic [15:0] frame_no_q, frame_no_d;
    logic        overflow_q, overflow_d;
    logic        done_q, done_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;

    logic                     fifo_we, fifo_re, fifo_full, fifo_empty;
    logic [31:0]              fifo_dout;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    line_buf_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_line_buf (
        .clk   (clk),
        .reset (reset),
        .din   (buf_dout),
        .we    (fifo_we),
        .re    (fifo_re),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Strobes decode straight from state so an async reset drops them in the same cycle.
    assign sending   = (state_q != ST_IDLE);
    assign kick      = (state_q == ST_KICK);
    assign w_req     = (state_q == ST_REQ);
    assign w_enable  = (state_q == ST_SEND);
    assign done      = done_q;
    assign frame_no  = frame_no_q;
    assign overflow  = overflow_q;
    assign read_addr = addr_q;
    assign read_num  = 32'(LINE_WORDS);

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        num_lines_d = num_lines_q;
        addr_d      = addr_q;
        dst_ip_d    = dst_ip_q;
        ports_d     = ports_q;
        frame_no_d  = frame_no_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        fifo_re     = 1'b0;
        fifo_we     = (state_q == ST_FILL) && buf_we && (fifo_count < LINE_CNT) && !fifo_full;

        if (buf_we && !fifo_we) overflow_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_lines_d = num_lines;
                    addr_d      = base_addr;
                    dst_ip_d    = dst_ip;
                    ports_d     = {src_port, dst_port};
                    line_d      = '0;
                    state_d     = (num_lines == '0) ? ST_DONE : ST_KICK;
                end
            end
            ST_KICK: state_d = ST_FILL;
            ST_FILL: begin
                if (fifo_count == LINE_CNT && !busy) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (w_ack) begin
                    word_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                word_cnt_d = word_cnt_q + 16'd1;
                fifo_re    = (word_cnt_q >= 16'(HDR_WORDS)) && !fifo_empty;
                if (word_cnt_q == LAST_WORD) begin
                    line_d    = line_q + 16'd1;
                    addr_d    = addr_q + LINE_BYTES;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 32'd1;
                if (gap_cnt_q >= GAP_LAST) state_d = (line_q == num_lines_q) ? ST_DONE : ST_KICK;
            end
            ST_DONE: begin
                done_d     = 1'b1;
                frame_no_d = frame_no_q + 16'd1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_data = '0;
        if (state_q == ST_SEND) begin
            if (word_cnt_q == 16'(HDR_IDX_IP))         w_data = dst_ip_q;
            else if (word_cnt_q == 16'(HDR_IDX_PORTS)) w_data = ports_q;
            else if (word_cnt_q == 16'(HDR_IDX_LEN))   w_data = {PAYLOAD_BYTES, 16'h0000};
            else if (word_cnt_q == 16'(HDR_IDX_APP))   w_data = {frame_no_q, line_q};
            else                                       w_data = fifo_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            num_lines_q <= '0;
            addr_q      <= '0;
            dst_ip_q    <= '0;
            ports_q     <= '0;
            frame_no_q  <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            word_cnt_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            num_lines_q <= num_lines_d;
            addr_q      <= addr_d;
            dst_ip_q    <= dst_ip_d;
            ports_q     <= ports_d;
            frame_no_q  <= frame_no_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_udp_stream_sender.sv
// Scoreboard bench for udp_stream_sender with DRAM read-engine and UPL ack models.
module tb_udp_stream_sender;

    localparam int LW  = 4;
    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_lines = '0;
    logic [31:0] base_addr = '0;
    logic [31:0] dst_ip = '0;
    logic [15:0] src_port = '0;
    logic [15:0] dst_port = '0;
    logic        sending, done, overflow, kick, w_req, w_enable;
    logic [15:0] frame_no;
    logic [31:0] read_num, read_addr, w_data;
    logic        busy = 1'b0;
    logic [31:0] buf_dout = '0;
    logic        buf_we = 1'b0;
    logic        w_ack = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_word[$];
    logic [31:0] exp_kick[$];
    logic [15:0] exp_frame = '0;
    logic [31:0] mem_seed = '0;
    bit          extra_we = 1'b0;
    int          ack_delay = 0;
    int          cyc = 0;

    udp_stream_sender #(.LINE_WORDS(LW), .FIFO_DEPTH_LOG2(3), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
        .base_addr(base_addr), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
        .sending(sending), .done(done), .frame_no(frame_no), .overflow(overflow),
        .kick(kick), .busy(busy), .read_num(read_num), .read_addr(read_addr),
        .buf_dout(buf_dout), .buf_we(buf_we), .w_req(w_req), .w_ack(w_ack),
        .w_enable(w_enable), .w_data(w_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Queue the expected kicks and packet words for a frame, then pulse start.
    task automatic applyStimulus(input logic [15:0] nl, input logic [31:0] base, input logic [31:0] ip,
                                 input logic [15:0] sp, input logic [15:0] dp);
        for (int l = 0; l < int'(nl); l++) begin
            exp_kick.push_back(base + 32'(l) * 32'd16);
            exp_word.push_back(ip);
            exp_word.push_back({sp, dp});
            exp_word.push_back(32'h0014_0000);
            exp_word.push_back({exp_frame, 16'(l)});
            for (int i = 0; i < LW; i++) exp_word.push_back(mem_seed + 32'(l) * 32'd16 + 32'(i) + 32'd1);
        end
        @(posedge clk); #1;
        num_lines = nl; base_addr = base; dst_ip = ip; src_port = sp; dst_port = dp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({name, " done seen"}, 32'(seen), 32'd1);
        checkOutput({name, " frame_no"}, 32'(frame_no), 32'(exp_frame + 16'd1));
        checkOutput({name, " sending low"}, 32'(sending), 32'd0);
        checkOutput({name, " words left"}, 32'(exp_word.size()), 32'd0);
        exp_frame = exp_frame + 16'd1;
    endtask

    // DRAM read engine: short latency, then LW words (one extra when extra_we is set).
    initial begin
        forever begin
            @(negedge clk);
            if (kick && !reset) begin
                busy = 1'b1;
                repeat (2) @(negedge clk);
                for (int i = 0; i < (extra_we ? LW + 1 : LW); i++) begin
                    buf_dout = mem_seed + 32'(i) + 32'd1;
                    buf_we = 1'b1;
                    @(negedge clk);
                end
                buf_we = 1'b0;
                busy = 1'b0;
                mem_seed = mem_seed + 32'd16;
            end
        end
    end

    // UPL grant model: ack after ack_delay request cycles, held for one cycle.
    initial begin
        int ack_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                w_ack = 1'b0; ack_cnt = 0;
            end else if (w_ack) begin
                w_ack = 1'b0; ack_cnt = 0;
            end else if (w_req) begin
                if (ack_cnt == ack_delay) w_ack = 1'b1;
                else ack_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on each kick and each w_enable beat.
    initial begin
        int en_run = 0;
        int req_run = 0;
        int last_en = 0;
        bit seen_pkt = 1'b0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                en_run = 0; req_run = 0; seen_pkt = 1'b0;
            end else begin
                if (kick) begin
                    if (exp_kick.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected kick: read_addr 0x%08h, none expected", read_addr);
                    end else begin
                        e = exp_kick.pop_front();
                        checkOutput("kick read_addr", read_addr, e);
                        checkOutput("kick read_num", read_num, 32'(LW));
                        if (seen_pkt) checkOutput("gap before kick", 32'(cyc - last_en), 32'(GAP + 1));
                    end
                end
                if (w_enable) begin
                    if (exp_word.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected w_enable: w_data 0x%08h, none expected", w_data);
                    end else begin
                        e = exp_word.pop_front();
                        checkOutput("w_data", w_data, e);
                    end
                    en_run++; last_en = cyc; seen_pkt = 1'b1;
                end else if (en_run > 0) begin
                    checkOutput("burst length", 32'(en_run), 32'(LW + 4));
                    en_run = 0;
                end
                if (w_req) req_run++;
                else if (req_run > 0) begin
                    checkOutput("req cycles", 32'(req_run), 32'(ack_delay + 1));
                    checkOutput("data right after ack", 32'(w_enable), 32'd1);
                    req_run = 0;
                end
                if (done) seen_pkt = 1'b0;
            end
        end
    end

    initial begin
        bit seen;
        #1;
        checkOutput("reset sending", 32'(sending), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset kick", 32'(kick), 32'd0);
        checkOutput("reset w_req", 32'(w_req), 32'd0);
        checkOutput("reset w_enable", 32'(w_enable), 32'd0);
        checkOutput("reset frame_no", 32'(frame_no), 32'd0);
        checkOutput("reset read_addr", read_addr, 32'd0);
        repeat (2) @(posedge clk); #3;
        reset = 1'b0;

        $display("[TB] single line");
        applyStimulus(16'd1, 32'h100, 32'h0a00_0003, 16'h4000, 16'h4001);
        waitDone("single");
        checkOutput("single overflow", 32'(overflow), 32'd0);

        $display("[TB] multi line");
        applyStimulus(16'd3, 32'h100, 32'h0a00_0003, 16'h4000, 16'h4001);
        waitDone("multi");

        $display("[TB] ack stall");
        ack_delay = 50;
        applyStimulus(16'd1, 32'h180, 32'hc0a8_0001, 16'h1234, 16'h5678);
        waitDone("stall");
        ack_delay = 0;

        $display("[TB] zero lines");
        applyStimulus(16'd0, 32'h500, 32'h0a00_0009, 16'h1, 16'h2);
        checkOutput("zero sending up", 32'(sending), 32'd1);
        checkOutput("zero done not yet", 32'(done), 32'd0);
        @(posedge clk); #1;
        checkOutput("zero done pulse", 32'(done), 32'd1);
        checkOutput("zero sending low", 32'(sending), 32'd0);
        checkOutput("zero frame_no", 32'(frame_no), 32'(exp_frame + 16'd1));
        exp_frame = exp_frame + 16'd1;

        $display("[TB] start while sending");
        applyStimulus(16'd1, 32'h200, 32'h0a00_0005, 16'h1111, 16'h2222);
        repeat (3) @(posedge clk); #1;
        num_lines = 16'd5; base_addr = 32'h900; dst_ip = 32'hdead_beef; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone("ignored start");
        repeat (20) @(negedge clk);
        checkOutput("no second frame", 32'(sending), 32'd0);

        $display("[TB] address wrap");
        applyStimulus(16'd2, 32'hFFFF_FFF8, 32'h0a00_0007, 16'h7000, 16'h7001);
        waitDone("wrap");

        $display("[TB] overflow");
        extra_we = 1'b1;
        applyStimulus(16'd1, 32'h40, 32'h0a00_0008, 16'h8000, 16'h8001);
        waitDone("overflow");
        checkOutput("overflow sticky", 32'(overflow), 32'd1);
        extra_we = 1'b0;

        $display("[TB] reset mid-send");
        applyStimulus(16'd1, 32'h300, 32'h0a00_000a, 16'h9000, 16'h9001);
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (w_enable) begin
                @(negedge clk);
                seen = 1'b1;
            end
        end
        checkOutput("reached send", 32'(seen), 32'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        checkOutput("abort w_enable", 32'(w_enable), 32'd0);
        checkOutput("abort w_req", 32'(w_req), 32'd0);
        checkOutput("abort overflow", 32'(overflow), 32'd0);
        checkOutput("abort sending", 32'(sending), 32'd0);
        checkOutput("abort frame_no", 32'(frame_no), 32'd0);
        exp_word.delete();
        exp_kick.delete();
        exp_frame = '0;
        @(posedge clk); #3;
        reset = 1'b0;

        $display("[TB] frame after reset");
        applyStimulus(16'd1, 32'h400, 32'h0a00_000b, 16'ha000, 16'ha001);
        waitDone("after reset");
        checkOutput("after reset overflow", 32'(overflow), 32'd0);
        checkOutput("kicks left", 32'(exp_kick.size()), 32'd0);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_stream_sender.md
Name: udp_stream_sender

Overview:
- Transmit counterpart of the UDP stream receive path. It reads an image frame from DDR3 line by line through the existing DRAM read engine (kick/busy/read_num/read_addr, then buf_dout/buf_we).
- Each line is packed into one UDP packet and pushed into the e7udpip UPL send port (Request/Ack/Enable/Data) in the ui_clk domain.
- Sits beside hdmi_gen and drives pUdp0Send_* when streaming is enabled.

Parameters:
- LINE_WORDS, 256, payload words (32-bit) read from DRAM per packet; range 1..1024.
- FIFO_DEPTH_LOG2, 10, log2 of line-buffer depth; 2**FIFO_DEPTH_LOG2 >= LINE_WORDS.
- GAP_CYCLES, 64, idle clocks between packets; 0 is legal.

Ports:
- clk  in  1  ui_clk; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a frame; ignored unless sending=0
- num_lines  in  16  lines in the frame, sampled on start
- base_addr  in  32  DRAM byte address of line 0, sampled on start
- dst_ip  in  32  destination IP, sampled on start
- src_port  in  16  UDP source port, sampled on start
- dst_port  in  16  UDP destination port, sampled on start
- sending  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of frame
- frame_no  out  16  completed-frame counter
- overflow  out  1  sticky; buf_we seen with no room or outside FILL
- kick  out  1  one-cycle DRAM read request
- busy  in  1  DRAM read engine busy
- read_num  out  32  words to read; constant LINE_WORDS
- read_addr  out  32  byte address of the current line
- buf_dout  in  32  DRAM read data
- buf_we  in  1  DRAM read data valid
- w_req  out  1  UPL send request
- w_ack  in  1  UPL send grant
- w_enable  out  1  UPL data valid
- w_data  out  32  UPL data word

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM to IDLE; line and frame counters 0; overflow cleared. Assertion mid-packet aborts immediately with w_req/w_enable low in the same cycle (async).
- States: IDLE, KICK, FILL, REQ, SEND, GAP, DONE.
- IDLE: on start, latch the inputs, set line=0, addr=base_addr, sending=1.
  - num_lines=0: go to DONE.
  - Otherwise: go to KICK.
- KICK: kick=1 for exactly one cycle with read_addr=addr and read_num=LINE_WORDS → FILL.
- FILL: each buf_we pushes buf_dout into the line FIFO.
  - When the FIFO holds LINE_WORDS words and busy=0 → REQ.
  - buf_we while the FIFO already holds LINE_WORDS words: the word is dropped and overflow is set.
- REQ: w_req=1 and held until the cycle w_ack=1 is sampled → SEND.
  - w_req deasserts on the first SEND cycle.
- SEND: w_enable=1 for exactly 4+LINE_WORDS consecutive cycles, with no bubbles. Word order:
  - word 0: dst_ip
  - word 1: {src_port, dst_port}
  - word 2: {payload_bytes[15:0], 16'h0000}, where payload_bytes=(LINE_WORDS+1)*4
  - word 3: app header {frame_no[15:0], line[15:0]}
  - words 4..: FIFO pops in order
  - The FIFO is read one cycle ahead (show-ahead) so w_data is valid whenever w_enable=1.
- After the last word: line += 1; addr += LINE_WORDS*4, wrapping modulo 2**32 → GAP.
- GAP: count GAP_CYCLES clocks (0 means a single transit cycle). Then:
  - line == num_lines → DONE.
  - Otherwise → KICK.
- DONE: done=1 for one cycle; frame_no += 1 (wraps at 16 bits); sending=0 → IDLE.
- buf_we in any state other than FILL is ignored and sets overflow.
- start while sending=1 is ignored; latched parameters are unchanged.
- w_ack outside REQ is ignored.
- Latency from start to first w_req is at least 3 + the DRAM read latency. Packet-to-packet spacing is at least 4+LINE_WORDS+GAP_CYCLES+3 cycles.

Decomposition:
- Package udp_stream_pkg:
  - FSM state encoding (7 states, localparam constants)
  - UPL_HDR_WORDS=3 and APP_HDR_WORDS=1
  - header word index constants
  - payload_bytes width (16)
- Sub-module line_buf_fifo: synchronous single-clock FIFO.
  - Parameter: depth log2.
  - Ports: clk, reset (async high), din, we, re, dout (show-ahead), count, full, empty.
  - Inferred as distributed or block RAM.

Test Plan:
- Single line: LINE_WORDS=4, GAP=0, num_lines=1, base_addr=0x100, dst_ip=0x0a000003, ports 0x4000/0x4001; memory model returns 1,2,3,4 → one kick with read_addr=0x100, read_num=4. Stream is 0x0a000003, 0x40004001, 0x00140000, 0x00000000, 1, 2, 3, 4 on 8 consecutive w_enable cycles; then done pulse and frame_no=1.
- Multi-line: num_lines=3, LINE_WORDS=4 → read_addr values 0x100, 0x110, 0x120; app headers 0x00000000, 0x00000001, 0x00000002; GAP_CYCLES idle cycles between packets.
- Ack stall: hold w_ack low for 50 cycles → w_req stays high, w_enable stays 0. Ack on cycle 51 → data begins the next cycle with no bubbles.
- Edge cases:
  - num_lines=0 → no kick; done one cycle after sending rises.
  - start while sending → ignored; the second frame's parameters are not latched.
  - base_addr=0xFFFFFFF8 with LINE_WORDS=4 → second line read_addr=0x00000008.
- Overflow/reset: inject 5 buf_we for LINE_WORDS=4 → 5th dropped, overflow=1, packet still carries words 1-4. Reset asserted mid-SEND → w_enable/w_req drop immediately, overflow clears, the next start runs cleanly.
